// File: rtl/sdram_line_client.sv
// sdram_line_client: cache-side initiator for a full-page burst SDRAM
// controller. It holds one line buffer, fills it from SDRAM with a read
// burst and flushes it back with a write burst. Host logic uses a simple
// word port into the buffer while the block is idle.
module sdram_line_client #(
  parameter int WORDS   = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        req_fill,
  input  logic        req_flush,
  input  logic [23:0] line_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [6:0]  buf_addr,
  input  logic        buf_we,
  input  logic [15:0] buf_wdata,
  output logic [15:0] buf_rdata,
  output logic        ctl_rd,
  output logic        ctl_wr,
  output logic [23:0] ctl_ad,
  input  logic        ctl_get,
  input  logic        ctl_put,
  input  logic [15:0] ctl_rdata,
  output logic [15:0] ctl_wdata,
  input  logic        ctl_calib
);

  localparam int PW = $clog2(WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] XFER_RD = 3'd2;
  localparam logic [2:0] XFER_WR = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  logic [2:0]    r_state;
  logic          r_dir;      // 1 = write burst (flush), 0 = read burst (fill)
  logic [PW-1:0] r_ptr;
  logic          r_full;     // all WORDS words transferred; r_ptr saturates
  logic [TW-1:0] r_tcnt;
  logic          r_rd;
  logic          r_wr;
  logic [23:0]   r_ad;
  logic [15:0]   r_wdata;
  logic [15:0]   r_rdata;
  logic          r_done;
  logic          r_err;
  logic [15:0]   r_mem [WORDS];

  logic          w_idle;
  logic          w_start;
  logic          w_ctl_wr_mem;
  logic          w_adv_wr;
  logic          w_adv;
  logic          w_mem_we;
  logic [PW-1:0] w_maddr;
  logic [15:0]   w_mdata;
  logic [15:0]   w_rword;

  assign w_idle  = (r_state == IDLE);
  assign w_start = w_idle && (req_fill || req_flush);

  // A get in REQ carries word 0, so it is stored just like a get in XFER_RD.
  assign w_ctl_wr_mem = ((r_state == REQ) && !r_dir && ctl_get) ||
                        ((r_state == XFER_RD) && ctl_get && !r_full);
  // The put that ends REQ is put cycle 0 and fetches word 0.
  assign w_adv_wr     = ((r_state == REQ) && r_dir && ctl_put) ||
                        ((r_state == XFER_WR) && ctl_put && !r_full);
  assign w_adv        = w_ctl_wr_mem || w_adv_wr;

  // Host owns the buffer port only while idle; otherwise the pointer does.
  assign w_mem_we = (w_idle && buf_we) || w_ctl_wr_mem;
  assign w_maddr  = w_idle ? buf_addr : r_ptr;
  assign w_mdata  = w_idle ? buf_wdata : ctl_rdata;
  assign w_rword  = r_mem[w_maddr];

  assign busy      = !w_idle;
  assign done      = r_done;
  assign err       = r_err;
  assign buf_rdata = r_rdata;
  assign ctl_rd    = r_rd;
  assign ctl_wr    = r_wr;
  assign ctl_ad    = r_ad;
  assign ctl_wdata = r_wdata;

  // Line buffer storage; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (w_mem_we) r_mem[w_maddr] <= w_mdata;
  end

  // Host read register updates only while idle and holds during a transfer.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)      r_rdata <= '0;
    else if (w_idle) r_rdata <= w_rword;
  end

  // Write data to the controller: one buffer word per accepted put.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        r_wdata <= '0;
    else if (w_adv_wr) r_wdata <= w_rword;
  end

  // Saturating word pointer with a terminal flag instead of wrapping.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (w_start) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (w_adv) begin
      if (r_ptr == PW'(WORDS - 1)) r_full <= 1'b1;
      else                         r_ptr  <= r_ptr + PW'(1);
    end
  end

  // Transfer sequencing: request handshake, burst tracking, completion.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dir   <= 1'b0;
      r_tcnt  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ad    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (w_start) begin
            r_ad    <= line_addr;
            r_dir   <= req_flush;   // flush wins over a simultaneous fill
            r_tcnt  <= '0;
            r_state <= REQ;
          end
        end
        REQ: begin
          // The request must fall right after the first data strobe so the
          // controller does not see it again in standby and start a second burst.
          if (!r_dir && ctl_get) begin
            r_rd    <= 1'b0;
            r_state <= XFER_RD;
          end else if (r_dir && ctl_put) begin
            r_wr    <= 1'b0;
            r_state <= XFER_WR;
          end else if (ctl_calib) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= FIN;
          end else begin
            r_rd   <= !r_dir;
            r_wr   <= r_dir;
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        XFER_RD: begin
          if (!ctl_get) begin
            r_done  <= 1'b1;
            r_err   <= !r_full;
            r_state <= FIN;
          end
        end
        XFER_WR: begin
          if (!ctl_put) begin
            r_done  <= 1'b1;
            r_err   <= !r_full;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_line_client.sv
// Bench for sdram_line_client: a simple controller model drives get/put,
// a reference copy of the line buffer predicts data, and a scoreboard
// monitor compares done/err, write data and host read data.
module tb_sdram_line_client;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        req_fill, req_flush;
  logic [23:0] line_addr;
  logic        busy, done, err;
  logic [6:0]  buf_addr;
  logic        buf_we;
  logic [15:0] buf_wdata, buf_rdata;
  logic        ctl_rd, ctl_wr;
  logic [23:0] ctl_ad;
  logic        ctl_get, ctl_put;
  logic [15:0] ctl_rdata, ctl_wdata;
  logic        ctl_calib;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_buf [128];
  logic        q_done [$];
  logic [15:0] q_wd   [$];
  logic [15:0] q_rd   [$];
  logic        rd_req;
  logic        put_q, rdreq_q;

  always #5 clk_in = ~clk_in;

  sdram_line_client #(.WORDS(128), .TIMEOUT(1023)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .req_fill(req_fill), .req_flush(req_flush), .line_addr(line_addr),
    .busy(busy), .done(done), .err(err),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata),
    .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_ad(ctl_ad),
    .ctl_get(ctl_get), .ctl_put(ctl_put), .ctl_rdata(ctl_rdata),
    .ctl_wdata(ctl_wdata), .ctl_calib(ctl_calib)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs seen at each active edge, for the monitor to use half a cycle later.
  always @(posedge clk_in) begin
    put_q   <= ctl_put;
    rdreq_q <= rd_req;
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk_in);
      if (done === 1'b1) begin
        if (q_done.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else                    chk("done_err", 32'(err), 32'(q_done.pop_front()));
      end
      if (put_q === 1'b1 && q_wd.size() > 0)
        chk("ctl_wdata", 32'(ctl_wdata), 32'(q_wd.pop_front()));
      if (rdreq_q === 1'b1) begin
        if (q_rd.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
        else                  chk("buf_rdata", 32'(buf_rdata), 32'(q_rd.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // All tasks start and end 1 time unit after an active edge.
  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic host_write(input int a, input logic [15:0] d);
    buf_addr = 7'(a); buf_wdata = d; buf_we = 1'b1;
    ref_buf[a] = d;
    tick();
    buf_we = 1'b0;
  endtask

  task automatic host_read(input int a);
    buf_addr = 7'(a); rd_req = 1'b1;
    q_rd.push_back(ref_buf[a]);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string nm);
    for (int i = 0; i < bound && busy; i++) tick();
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic request(input logic fill, input logic flush, input logic [23:0] a);
    line_addr = a; req_fill = fill; req_flush = flush;
    tick();
    req_fill = 1'b0; req_flush = 1'b0;
    chk("busy_after_req", 32'(busy), 32'd1);
    chk("ctl_ad", 32'(ctl_ad), 32'(a));
  endtask

  task automatic wait_req(input logic wr);
    for (int i = 0; i < 8 && (wr ? ctl_wr : ctl_rd) !== 1'b1; i++) tick();
    chk(wr ? "ctl_wr_rise" : "ctl_rd_rise", 32'(wr ? ctl_wr : ctl_rd), 32'd1);
  endtask

  task automatic do_fill(input logic [23:0] a, input int n, input logic pattern, input int calib);
    if (calib > 0) ctl_calib = 1'b1;
    request(1'b1, 1'b0, a);
    if (calib > 0) begin
      for (int i = 0; i < calib; i++) begin
        chk("rd_low_in_calib", 32'(ctl_rd), 32'd0);
        chk("busy_in_calib", 32'(busy), 32'd1);
        tick();
      end
      ctl_calib = 1'b0;
      tick();
      chk("rd_after_calib", 32'(ctl_rd), 32'd1);
    end
    wait_req(1'b0);
    repeat ($urandom_range(0, 2)) tick();
    for (int k = 0; k < n; k++) begin
      ctl_get = 1'b1;
      ctl_rdata = pattern ? 16'(16'hA000 + k) : 16'($urandom);
      if (k < 128) ref_buf[k] = ctl_rdata;
      tick();
      if (k == 0) chk("rd_drop", 32'(ctl_rd), 32'd0);
    end
    ctl_get = 1'b0;
    q_done.push_back(n < 128);
    wait_idle(10, "fill_idle");
  endtask

  task automatic do_flush(input logic [23:0] a, input int n, input logic both, input logic interfere);
    request(both, 1'b1, a);
    wait_req(1'b1);
    chk("no_rd_on_flush", 32'(ctl_rd), 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    for (int k = 0; k < n; k++) begin
      ctl_put = 1'b1;
      if (k < 128) q_wd.push_back(ref_buf[k]);
      if (interfere && k == 10) begin
        req_fill = 1'b1; buf_we = 1'b1; buf_addr = 7'd5; buf_wdata = ~ref_buf[5];
      end
      tick();
      req_fill = 1'b0; buf_we = 1'b0;
      if (k == 0) chk("wr_drop", 32'(ctl_wr), 32'd0);
    end
    ctl_put = 1'b0;
    q_done.push_back(n < 128);
    wait_idle(10, "flush_idle");
    for (int i = 0; i < 3; i++) begin
      chk("no_queued_req", 32'({ctl_rd, busy}), 32'd0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; req_fill = 0; req_flush = 0; line_addr = '0;
    buf_addr = '0; buf_we = 0; buf_wdata = '0; rd_req = 0;
    ctl_get = 0; ctl_put = 0; ctl_rdata = '0; ctl_calib = 0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_rd_wr", 32'({ctl_rd, ctl_wr}), 32'd0);
    chk("rst_ad", 32'(ctl_ad), 32'd0);
    chk("rst_wdata", 32'(ctl_wdata), 32'd0);
    chk("rst_rdata", 32'(buf_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 128; a++) host_write(a, 16'($urandom));

    // Directed fill with a recognisable pattern.
    do_fill(24'h012345, 128, 1'b1, 0);
    host_read(0); host_read(127); host_read(64);

    // Directed flush of k*3.
    for (int a = 0; a < 128; a++) host_write(a, 16'(a * 3));
    do_flush(24'h000777, 128, 1'b0, 1'b0);

    // Calibration gating.
    do_fill(24'h0000AA, 128, 1'b0, 50);
    host_read(1);

    // Short read burst.
    do_fill(24'h00BEEF, 100, 1'b0, 0);
    host_read(99); host_read(100);

    // No response: timeout.
    request(1'b1, 1'b0, 24'h00DEAD);
    wait_req(1'b0);
    q_done.push_back(1'b1);
    wait_idle(1100, "timeout_idle");
    chk("timeout_rd_drop", 32'(ctl_rd), 32'd0);

    // Simultaneous requests plus mid-burst interference.
    do_flush(24'h00C0DE, 128, 1'b1, 1'b1);
    host_read(5);

    // Randomised mix of transfers.
    for (int it = 0; it < 6; it++) begin
      int n;
      case ($urandom_range(0, 2))
        0:       n = 128;
        1:       n = 130;
        default: n = $urandom_range(20, 127);
      endcase
      if ($urandom_range(0, 1) == 1) do_fill(24'($urandom), n, 1'b0, 0);
      else                           do_flush(24'($urandom), n, 1'b0, 1'b0);
      for (int r = 0; r < 3; r++) host_read($urandom_range(0, 127));
    end

    // Reset while the write request is pending.
    request(1'b0, 1'b1, 24'h000123);
    wait_req(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_wr", 32'(ctl_wr), 32'd0);
    chk("rst_req_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a read burst at word 60.
    request(1'b1, 1'b0, 24'h000456);
    wait_req(1'b0);
    for (int k = 0; k < 60; k++) begin
      ctl_get = 1'b1;
      ctl_rdata = 16'($urandom);
      ref_buf[k] = ctl_rdata;
      tick();
    end
    ctl_get = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rd_done", 32'({ctl_rd, ctl_wr, done}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    host_read(0); host_read(59); host_read(60);

    // Block accepts a new fill after reset.
    do_fill(24'h00F00D, 128, 1'b0, 0);
    for (int r = 0; r < 4; r++) host_read($urandom_range(0, 127));

    repeat (3) tick();
    chk("q_done_empty", 32'(q_done.size()), 32'd0);
    chk("q_wd_empty", 32'(q_wd.size()), 32'd0);
    chk("q_rd_empty", 32'(q_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_line_client.md
Name: sdram_line_client

Overview:
- Cache-side initiator for the 128-word full-page burst SDRAM controller: it drives the controller's rd/wr/ad request inputs and consumes its get/put/dout data stream.
- Holds one 128 x 16-bit line buffer:
  - fill: SDRAM -> buffer, via a read burst.
  - flush: buffer -> SDRAM, via a write burst.
- Host logic, such as a cache tag unit, accesses the buffer through a simple word port while the block is idle.

Parameters:
- WORDS, 128, words per burst; fixed to match the controller's 256-byte burst; pointer width is log2(WORDS).
- TIMEOUT, 1023, cycles allowed from request assertion to the first get/put before aborting with err.

Ports:
- clk_in  in  1  controller clock; same clock as the SDRAM controller.
- rst_n  in  1  asynchronous active-low reset.
- req_fill  in  1  one-cycle pulse: load line line_addr into the buffer.
- req_flush  in  1  one-cycle pulse: write the buffer to line line_addr.
- line_addr  in  24  line address; drives the controller's ad.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at the end of a transfer.
- err  out  1  valid with done: short burst or timeout.
- buf_addr  in  7  host word address.
- buf_we  in  1  host write strobe.
- buf_wdata  in  16  host write data.
- buf_rdata  out  16  host read data; 1-cycle latency.
- ctl_rd  out  1  to controller rd.
- ctl_wr  out  1  to controller wr.
- ctl_ad  out  24  to controller ad.
- ctl_get  in  1  from controller get; a read word is valid this cycle.
- ctl_put  in  1  from controller put; the controller wants the next write word.
- ctl_rdata  in  16  from controller dout.
- ctl_wdata  out  16  to controller din.
- ctl_calib  in  1  controller initialising.

Behaviour:

Reset:
- Asynchronous, active-low. All outputs go to 0, the FSM goes to IDLE and all pointers/counters clear.
- Buffer contents are not reset.
- Reset mid-burst drops ctl_rd/ctl_wr immediately. No done pulse is produced.

FSM states: IDLE, REQ, XFER_RD, XFER_WR, FIN.

IDLE:
- busy=0.
- buf_we writes buf[buf_addr] <= buf_wdata at the clock edge.
- buf_rdata <= buf[buf_addr] every cycle.
- On req_flush:
  - Latch line_addr into ctl_ad and set dir=wr.
  - req_flush beats req_fill if both are asserted in the same cycle; req_fill is dropped.
- On req_fill alone: latch line_addr and set dir=rd.
- In both cases: clear the pointer and the timeout counter, go to REQ, busy=1 from the next cycle.

REQ:
- While ctl_calib=1: ctl_rd/ctl_wr stay 0 and the timeout counter is held.
- Otherwise: assert ctl_rd (dir=rd) or ctl_wr (dir=wr) and increment the timeout counter.
- Rd request: the first cycle with ctl_get=1 deasserts ctl_rd on the next edge, captures word 0 in that same cycle, and moves to XFER_RD.
- Wr request: the first cycle with ctl_put=1 deasserts ctl_wr and moves to XFER_WR.
- The request must drop before the controller re-samples in standby, which otherwise issues a second burst.
- Counter reaching TIMEOUT: drop the request, go to FIN with err=1.

XFER_RD:
- On each edge with ctl_get=1 and ptr<WORDS: buf[ptr] <= ctl_rdata, ptr++.
- get cycles after ptr==WORDS are ignored; no write, no wrap.
- ctl_get falling with ptr==WORDS: go to FIN, err=0.
- ctl_get falling with ptr<WORDS: go to FIN, err=1.

XFER_WR:
- On each edge with ctl_put=1 and ptr<WORDS: ctl_wdata <= buf[ptr], ptr++. Word k appears on ctl_wdata one cycle after the k-th put cycle.
- The REQ->XFER_WR transition cycle counts as put cycle 0.
- With ptr==WORDS, ctl_wdata holds the last word.
- ctl_put falling: go to FIN; err=1 if ptr<WORDS, else err=0.

FIN:
- done=1 for one cycle, err valid in that cycle.
- busy=0 and state=IDLE on the next cycle.

While busy:
- buf_we is ignored.
- buf_rdata holds its last value.
- req_fill/req_flush are ignored; they are not queued.

Pointer: 7-bit saturating counter with a separate terminal flag; it never wraps to 0.

Test Plan:
- Fill: pulse req_fill, line_addr=0x012345; model answers get for 128 cycles with ctl_rdata=0xA000+k -> ctl_ad=0x012345, ctl_rd drops after the first get, done=1 with err=0; host reads buf[0]=0xA000 and buf[127]=0xA07F.
- Flush: host writes buf[k]=k*3, pulse req_flush; model gives 128 put cycles -> ctl_wr drops after the first put; ctl_wdata sequence is 0,3,...,381, each one cycle after its put; done=1, err=0.
- Calib gating: ctl_calib=1 for 50 cycles after req_fill -> ctl_rd=0 and busy=1 throughout; ctl_rd rises the cycle after calib falls; no timeout occurs.
- Short burst / timeout: get for 100 cycles only -> done with err=1; a separate run with no response for 1023 cycles -> ctl_rd drops, done with err=1.
- Simultaneous/busy requests: req_fill and req_flush in the same cycle -> write burst only; req_fill mid-burst is ignored; buf_we mid-burst leaves the buffer unchanged.
- Reset mid-burst: rst_n low at word 60 -> ctl_rd/ctl_wr/busy/done drop asynchronously; after release the block is IDLE and accepts a new fill.
